// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle datapath: FSM states, opcodes,
// alu_op, pc_src and ALU B-operand mux selects. Also used by alu_control and
// the datapath.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned ALUB_W  = 2;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    EXEC    = 4'd7,
    ALU_WB  = 4'd8,
    ADDI_EX = 4'd9,
    ADDI_WB = 4'd10,
    BEQ     = 4'd11,
    JUMP    = 4'd12,
    ILLEGAL = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [ALUB_W-1:0] ALUB_REGB    = 2'b00;
  localparam logic [ALUB_W-1:0] ALUB_FOUR    = 2'b01;
  localparam logic [ALUB_W-1:0] ALUB_IMM     = 2'b10;
  localparam logic [ALUB_W-1:0] ALUB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: Moore FSM stepping the shared ALU/memory/regfile
// through fetch, decode, execute, memory and writeback, with memory wait states.
// Optional feature macro: ILLEGAL_TRAP_EN (ILLEGAL state becomes a sticky trap).
// Outputs decode the state register directly so that an asynchronous reset
// clears every strobe in the same cycle it rises.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [PCSRC_W-1:0] pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [ALUB_W-1:0]  alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op
);

  state_t state_q, state_d;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing, memory states stall on mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADR;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEM_ADR: state_d = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:  state_d = FETCH;
      MEM_WR:  if (mem_ready) state_d = FETCH;
      EXEC:    state_d = ALU_WB;
      ALU_WB:  state_d = FETCH;
      ADDI_EX: state_d = ADDI_WB;
      ADDI_WB: state_d = FETCH;
      BEQ:     state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
      ILLEGAL: state_d = ILLEGAL;
`else
      ILLEGAL: state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; FETCH/MEM_WR completion and BEQ taken add input gating.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REGB;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = ALUB_IMM_SH2;
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      ILLEGAL: illegal_op = 1'b1;
`else
      ILLEGAL: instr_done = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
